// File: rtl/fsm_transition_checker.sv
//------------------------------------------------------------------------------
// fsm_transition_checker
//
// Watches a 2-bit FSM state stream (for example the current_state of a
// sequencer). Each accepted sample is checked against a table of legal
// transitions, and an illegal transition is reported on a held error channel.
// Visits are also counted per state. When each fixed-length window of accepted
// samples closes, the checker reports which states were never reached in it.
//
// Ports
//   clk            : single clock, all logic on the rising edge
//   rst            : asynchronous, active-high reset
//   in_valid       : in_state carries a sample this cycle
//   in_ready       : checker can accept a sample (low while an error is pending)
//   in_state       : observed state encoding
//   err_valid      : illegal-transition report pending
//   err_ready      : report consumed when high together with err_valid
//   err_from       : previous state of the illegal transition
//   err_to         : new state of the illegal transition
//   visit_sel      : selects which per-state counter drives visit_cnt
//   visit_cnt      : live current-window visit count of state visit_sel
//   window_done    : one-cycle pulse after the window-closing sample
//   unreached_mask : bit s set if state s had no visits in the last closed window
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module fsm_transition_checker #(
    parameter int          CNT_W       = 8,
    parameter int          WINDOW      = 16,
    parameter logic [15:0] LEGAL_MASK  = 16'h0112,
    parameter logic [1:0]  RESET_STATE = 2'b00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_state,
    output logic             err_valid,
    input  logic             err_ready,
    output logic [1:0]       err_from,
    output logic [1:0]       err_to,
    input  logic [1:0]       visit_sel,
    output logic [CNT_W-1:0] visit_cnt,
    output logic             window_done,
    output logic [3:0]       unreached_mask
);

    // The sample counter only has to hold 0..WINDOW-1. It returns to 0 on the
    // edge that accepts the last sample of a window.
    localparam int               SC_W     = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [SC_W-1:0]  LAST_IDX = SC_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        TRACK  = 1'b0,
        REPORT = 1'b1
    } ctl_state_t;

    ctl_state_t       state_reg;
    ctl_state_t       state_next;

    logic [1:0]       prev_reg;
    logic [SC_W-1:0]  sample_cnt_reg;
    logic [CNT_W-1:0] visit_cnt_reg [4];
    logic [3:0]       visited_reg;
    logic [3:0]       unreached_reg;
    logic             window_done_reg;
    logic [1:0]       err_from_reg;
    logic [1:0]       err_to_reg;

    logic             accept;
    logic             illegal;
    logic             window_close;
    logic [3:0]       hit;

    //--------------------------------------------------------------------------
    // Accept and transition classification
    //--------------------------------------------------------------------------
    assign accept = in_valid && in_ready;

    // A repeated state is always legal. Any other step is looked up in the mask
    // at bit index {from, to}, which equals from*4+to.
    assign illegal = accept && (in_state != prev_reg)
                     && !LEGAL_MASK[{prev_reg, in_state}];

    assign window_close = accept && (sample_cnt_reg == LAST_IDX);

    //--------------------------------------------------------------------------
    // Control FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= TRACK;
        end else begin
            state_reg <= state_next;
        end
    end

    //--------------------------------------------------------------------------
    // Control FSM: next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            TRACK: begin
                if (illegal) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                if (err_ready) begin
                    state_next = TRACK;
                end
            end
            default: begin
                state_next = TRACK;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Control FSM: outputs. in_ready must not depend on in_valid, so that the
    // producer sees a plain combinational function of the checker state.
    //--------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b1;
        err_valid = 1'b0;
        case (state_reg)
            TRACK: begin
                in_ready  = 1'b1;
                err_valid = 1'b0;
            end
            REPORT: begin
                in_ready  = 1'b0;
                err_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b1;
                err_valid = 1'b0;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Error report fields. They are loaded only on an illegal accept. That can
    // happen only in TRACK, so the fields stay frozen for the whole REPORT
    // state.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_from_reg <= 2'b00;
            err_to_reg   <= 2'b00;
        end else if (illegal) begin
            err_from_reg <= prev_reg;
            err_to_reg   <= in_state;
        end
    end

    assign err_from = err_from_reg;
    assign err_to   = err_to_reg;

    //--------------------------------------------------------------------------
    // Previous-state register. An illegal sample still becomes the new
    // reference state.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_reg <= RESET_STATE;
        end else if (accept) begin
            prev_reg <= in_state;
        end
    end

    //--------------------------------------------------------------------------
    // Window sample counter
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt_reg <= '0;
        end else if (window_close) begin
            sample_cnt_reg <= '0;
        end else if (accept) begin
            sample_cnt_reg <= sample_cnt_reg + 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Per-state visit counters and visited flags
    //--------------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_state
        assign hit[gi] = accept && (in_state == 2'(gi));

        // The close clears the counter even when the closing sample hits this
        // state, because that sample belongs to the window that just ended.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                visit_cnt_reg[gi] <= '0;
            end else if (window_close) begin
                visit_cnt_reg[gi] <= '0;
            end else if (hit[gi] && (visit_cnt_reg[gi] != CNT_MAX)) begin
                visit_cnt_reg[gi] <= visit_cnt_reg[gi] + 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                visited_reg[gi] <= 1'b0;
            end else if (window_close) begin
                visited_reg[gi] <= 1'b0;
            end else if (hit[gi]) begin
                visited_reg[gi] <= 1'b1;
            end
        end
    end

    assign visit_cnt = visit_cnt_reg[visit_sel];

    //--------------------------------------------------------------------------
    // Window close reporting. The closing sample's own state counts as
    // visited, so it is merged in through hit.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unreached_reg   <= 4'b0000;
            window_done_reg <= 1'b0;
        end else begin
            window_done_reg <= window_close;
            if (window_close) begin
                unreached_reg <= ~(visited_reg | hit);
            end
        end
    end

    assign window_done    = window_done_reg;
    assign unreached_mask = unreached_reg;

endmodule

// File: tb/tb_fsm_transition_checker.sv
//------------------------------------------------------------------------------
// tb_fsm_transition_checker
//
// Self-checking bench for fsm_transition_checker. It uses two instances:
//   dut_a : CNT_W=3, WINDOW=16 (the table, window, saturation and random runs)
//   dut_b : CNT_W=8, WINDOW=4  (window close that coincides with an illegal
//           sample, then reset while an error is pending)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fsm_transition_checker;

    localparam logic [15:0] LEGAL  = 16'h0112;
    localparam int          A_CW   = 3;
    localparam int          A_WIN  = 16;
    localparam int          A_MAX  = (1 << A_CW) - 1;

    logic clk;
    logic rst;

    logic             a_valid, a_ready, a_err_ready, a_err_valid, a_wd;
    logic [1:0]       a_state, a_from, a_to, a_sel;
    logic [A_CW-1:0]  a_cnt;
    logic [3:0]       a_um;

    logic             b_valid, b_ready, b_err_ready, b_err_valid, b_wd;
    logic [1:0]       b_state, b_from, b_to, b_sel;
    logic [7:0]       b_cnt;
    logic [3:0]       b_um;

    int n_total;
    int n_pass;

    fsm_transition_checker #(.CNT_W(A_CW), .WINDOW(A_WIN), .LEGAL_MASK(LEGAL),
                             .RESET_STATE(2'b00)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_valid), .in_ready(a_ready), .in_state(a_state),
        .err_valid(a_err_valid), .err_ready(a_err_ready),
        .err_from(a_from), .err_to(a_to),
        .visit_sel(a_sel), .visit_cnt(a_cnt),
        .window_done(a_wd), .unreached_mask(a_um)
    );

    fsm_transition_checker #(.CNT_W(8), .WINDOW(4), .LEGAL_MASK(LEGAL),
                             .RESET_STATE(2'b00)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_valid), .in_ready(b_ready), .in_state(b_state),
        .err_valid(b_err_valid), .err_ready(b_err_ready),
        .err_from(b_from), .err_to(b_to),
        .visit_sel(b_sel), .visit_cnt(b_cnt),
        .window_done(b_wd), .unreached_mask(b_um)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Vector records: inputs driven at the negative edge, and the outputs
    // expected just after the following rising edge.
    typedef struct {
        logic       v;
        logic [1:0] st;
        logic       er;
        logic [1:0] sel;
        logic       rdy;
        logic       ev;
        logic [1:0] from;
        logic [1:0] to;
        int         cnt;
        logic       wd;
        logic [3:0] um;
    } vec_t;

    vec_t tbl [23];

    // Behavioural reference model for the random run
    logic [1:0] m_prev;
    int         m_cnt [4];
    logic [3:0] m_vis;
    int         m_n;
    logic       m_err;
    logic [1:0] m_from, m_to;
    logic       m_wd;
    logic [3:0] m_um;

    function automatic logic is_legal(input logic [1:0] from, input logic [1:0] to);
        int bitpos;
        bitpos = int'(from) * 4 + int'(to);
        return (from == to) || (((LEGAL >> bitpos) & 16'h1) != 16'h0);
    endfunction

    task automatic model_reset();
        m_prev = 2'b00;
        for (int s = 0; s < 4; s++) m_cnt[s] = 0;
        m_vis  = 4'b0000;
        m_n    = 0;
        m_err  = 1'b0;
        m_from = 2'b00;
        m_to   = 2'b00;
        m_wd   = 1'b0;
        m_um   = 4'b0000;
    endtask

    task automatic model_step(input logic v, input logic [1:0] st, input logic er);
        logic close_now;
        close_now = 1'b0;
        if (m_err) begin
            if (er) m_err = 1'b0;
        end else if (v) begin
            if (!is_legal(m_prev, st)) begin
                m_err  = 1'b1;
                m_from = m_prev;
                m_to   = st;
            end
            if (m_cnt[st] < A_MAX) m_cnt[st] = m_cnt[st] + 1;
            m_vis[st] = 1'b1;
            m_prev    = st;
            m_n       = m_n + 1;
            if (m_n == A_WIN) begin
                close_now = 1'b1;
                m_um = ~m_vis;
                m_vis = 4'b0000;
                m_n = 0;
                for (int s = 0; s < 4; s++) m_cnt[s] = 0;
            end
        end
        m_wd = close_now;
    endtask

    initial begin
        logic [1:0] seq6 [4];
        n_total = 0;
        n_pass  = 0;
        rst = 1'b0;
        a_valid = 1'b0; a_state = 2'b00; a_err_ready = 1'b0; a_sel = 2'b00;
        b_valid = 1'b0; b_state = 2'b00; b_err_ready = 1'b0; b_sel = 2'b00;

        //            v     st     er    sel    rdy   ev    from   to   cnt wd    um
        tbl[0]  = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 1, 1'b0, 4'b0000};
        tbl[1]  = '{1'b1, 2'd1, 1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 2'd0, 1, 1'b0, 4'b0000};
        tbl[2]  = '{1'b1, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 2, 1'b0, 4'b0000};
        tbl[3]  = '{1'b1, 2'd1, 1'b0, 2'd1, 1'b1, 1'b0, 2'd0, 2'd0, 2, 1'b0, 4'b0000};
        tbl[4]  = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 3, 1'b0, 4'b0000};
        tbl[5]  = '{1'b1, 2'd2, 1'b0, 2'd2, 1'b0, 1'b1, 2'd0, 2'd2, 1, 1'b0, 4'b0000};
        tbl[6]  = '{1'b1, 2'd3, 1'b0, 2'd3, 1'b0, 1'b1, 2'd0, 2'd2, 0, 1'b0, 4'b0000};
        tbl[7]  = '{1'b1, 2'd1, 1'b0, 2'd1, 1'b0, 1'b1, 2'd0, 2'd2, 2, 1'b0, 4'b0000};
        tbl[8]  = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 2'd2, 3, 1'b0, 4'b0000};
        tbl[9]  = '{1'b1, 2'd3, 1'b0, 2'd2, 1'b0, 1'b1, 2'd0, 2'd2, 1, 1'b0, 4'b0000};
        tbl[10] = '{1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 2'd2, 3, 1'b0, 4'b0000};
        tbl[11] = '{1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 3, 1'b0, 4'b0000};
        tbl[12] = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 4, 1'b0, 4'b0000};
        tbl[13] = '{1'b1, 2'd1, 1'b0, 2'd1, 1'b1, 1'b0, 2'd0, 2'd0, 3, 1'b0, 4'b0000};
        tbl[14] = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5, 1'b0, 4'b0000};
        tbl[15] = '{1'b1, 2'd1, 1'b0, 2'd1, 1'b1, 1'b0, 2'd0, 2'd0, 4, 1'b0, 4'b0000};
        tbl[16] = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 6, 1'b0, 4'b0000};
        tbl[17] = '{1'b1, 2'd1, 1'b0, 2'd1, 1'b1, 1'b0, 2'd0, 2'd0, 5, 1'b0, 4'b0000};
        tbl[18] = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 7, 1'b0, 4'b0000};
        tbl[19] = '{1'b1, 2'd1, 1'b0, 2'd1, 1'b1, 1'b0, 2'd0, 2'd0, 6, 1'b0, 4'b0000};
        tbl[20] = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 7, 1'b0, 4'b0000};
        tbl[21] = '{1'b1, 2'd1, 1'b0, 2'd1, 1'b1, 1'b0, 2'd0, 2'd0, 0, 1'b1, 4'b1000};
        tbl[22] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 0, 1'b0, 4'b1000};

        // Asynchronous reset between clock edges
        #3 rst = 1'b1;
        #1;
        check("rst_in_ready_a", int'(a_ready), 1);
        check("rst_err_valid_a", int'(a_err_valid), 0);
        check("rst_unreached_a", int'(a_um), 0);
        check("rst_wd_b", int'(b_wd), 0);
        for (int s = 0; s < 4; s++) begin
            a_sel = 2'(s);
            b_sel = 2'(s);
            #1;
            check($sformatf("rst_visit_cnt_a[%0d]", s), int'(a_cnt), 0);
            check($sformatf("rst_visit_cnt_b[%0d]", s), int'(b_cnt), 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Table: legal stream, illegal 00->10 held five cycles, release, first
        // window close with state 11 never visited, and counter saturation at 7
        for (int i = 0; i < 23; i++) begin
            a_valid = tbl[i].v; a_state = tbl[i].st;
            a_err_ready = tbl[i].er; a_sel = tbl[i].sel;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_in_ready", i), int'(a_ready), int'(tbl[i].rdy));
            check($sformatf("tbl%0d_err_valid", i), int'(a_err_valid), int'(tbl[i].ev));
            if (tbl[i].ev) begin
                check($sformatf("tbl%0d_err_from", i), int'(a_from), int'(tbl[i].from));
                check($sformatf("tbl%0d_err_to", i), int'(a_to), int'(tbl[i].to));
            end
            check($sformatf("tbl%0d_visit_cnt", i), int'(a_cnt), tbl[i].cnt);
            check($sformatf("tbl%0d_window_done", i), int'(a_wd), int'(tbl[i].wd));
            check($sformatf("tbl%0d_unreached", i), int'(a_um), int'(tbl[i].um));
            @(negedge clk);
        end

        // Full window alternating 00/01: only states 10 and 11 unreached
        a_err_ready = 1'b0;
        a_sel = 2'd0;
        for (int i = 0; i < 16; i++) begin
            a_valid = 1'b1;
            a_state = 2'(i % 2);
            @(posedge clk);
            #1;
            check($sformatf("win_err_valid_%0d", i), int'(a_err_valid), 0);
            check($sformatf("win_done_%0d", i), int'(a_wd), (i == 15) ? 1 : 0);
            if (i < 15) begin
                check($sformatf("win_cnt00_%0d", i), int'(a_cnt),
                      (i / 2 + 1 > A_MAX) ? A_MAX : i / 2 + 1);
            end
            @(negedge clk);
        end
        check("win_unreached", int'(a_um), 4'b1100);
        check("win_cnt00_after_close", int'(a_cnt), 0);
        a_valid = 1'b0;
        @(posedge clk);
        #1;
        check("win_done_drop", int'(a_wd), 0);
        check("win_cnt00_idle", int'(a_cnt), 0);
        check("win_unreached_hold", int'(a_um), 4'b1100);
        @(negedge clk);

        // Ten repeated 00 samples saturate the 3-bit counter
        for (int k = 1; k <= 10; k++) begin
            a_valid = 1'b1;
            a_state = 2'd0;
            @(posedge clk);
            #1;
            check($sformatf("sat_cnt_%0d", k), int'(a_cnt), (k > A_MAX) ? A_MAX : k);
            check($sformatf("sat_err_%0d", k), int'(a_err_valid), 0);
            @(negedge clk);
        end
        a_valid = 1'b0;

        // WINDOW=4 instance: the closing sample is also illegal (00->11)
        seq6[0] = 2'd0; seq6[1] = 2'd1; seq6[2] = 2'd0; seq6[3] = 2'd3;
        b_sel = 2'd3;
        for (int i = 0; i < 4; i++) begin
            b_valid = 1'b1;
            b_state = seq6[i];
            @(posedge clk);
            #1;
            if (i < 3) begin
                check($sformatf("w4_err_%0d", i), int'(b_err_valid), 0);
                check($sformatf("w4_done_%0d", i), int'(b_wd), 0);
            end
            @(negedge clk);
        end
        b_valid = 1'b0;
        check("w4_err_valid", int'(b_err_valid), 1);
        check("w4_err_from", int'(b_from), 0);
        check("w4_err_to", int'(b_to), 3);
        check("w4_in_ready", int'(b_ready), 0);
        check("w4_window_done", int'(b_wd), 1);
        check("w4_unreached", int'(b_um), 4'b0100);
        check("w4_cnt11_cleared", int'(b_cnt), 0);
        @(posedge clk);
        #1;
        check("w4_done_drop", int'(b_wd), 0);
        check("w4_err_held", int'(b_err_valid), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("w4_rst_err_valid", int'(b_err_valid), 0);
        check("w4_rst_in_ready", int'(b_ready), 1);
        check("w4_rst_unreached", int'(b_um), 0);
        @(negedge clk);
        rst = 1'b0;

        // Random stimulus against the reference model
        model_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            a_valid     = ($urandom % 4) != 0;
            a_state     = 2'($urandom % 4);
            a_err_ready = ($urandom % 3) == 0;
            a_sel       = 2'($urandom % 4);
            #1;
            check($sformatf("rnd%0d_in_ready", c), int'(a_ready), int'(!m_err));
            check($sformatf("rnd%0d_err_valid", c), int'(a_err_valid), int'(m_err));
            if (m_err) begin
                check($sformatf("rnd%0d_err_from", c), int'(a_from), int'(m_from));
                check($sformatf("rnd%0d_err_to", c), int'(a_to), int'(m_to));
            end
            check($sformatf("rnd%0d_window_done", c), int'(a_wd), int'(m_wd));
            check($sformatf("rnd%0d_unreached", c), int'(a_um), int'(m_um));
            check($sformatf("rnd%0d_visit_cnt", c), int'(a_cnt), m_cnt[a_sel]);
            @(posedge clk);
            model_step(a_valid, a_state, a_err_ready);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
